clk_div_gen: RTL and testbench

CLK_DIV_GEN -- requirements
Module: clk_div_gen

---
 rtl/clk_div_gen.sv | 145 ++++++++++++++
 tb/tb_clk_div_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/clk_div_gen.sv
// Multi-channel divided-clock generator: per-channel divide/high/phase, aligned restart, lock indication.
// Optional rising-edge phase offset enabled by defining DIVGEN_PHASE_EN.
module clk_div_gen #(
  parameter  int NUM_CH      = 3,
  parameter  int CNT_W       = 8,
  parameter  int LOCK_CYCLES = 16,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] outclk_en,
  output logic              locked
);

  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {ALIGN, WAIT_LOCK, LOCKED} state_t;

  state_t            state, next_state;
  logic [LOCK_W-1:0] lock_cnt;
  logic [CNT_W-1:0]  div  [NUM_CH];
  logic [CNT_W-1:0]  high [NUM_CH];
  logic [CNT_W-1:0]  cnt  [NUM_CH];
`ifdef DIVGEN_PHASE_EN
  logic [CNT_W-1:0]  phase [NUM_CH];
`else
  logic              unused_phase;
  assign unused_phase = ^cfg_phase;
`endif

  logic accept, bad, wr_ok, run;

  always_comb begin
    accept = cfg_valid && cfg_ready;
    bad    = (cfg_div < CNT_W'(2)) || (cfg_high == '0) || (cfg_high >= cfg_div)
          || (int'(cfg_ch) >= NUM_CH);
`ifdef DIVGEN_PHASE_EN
    bad    = bad || (cfg_phase >= cfg_div);
`endif
    wr_ok  = accept && !bad;
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) state <= ALIGN;
    else     state <= next_state;
  end

  // Next-state logic
  // NOTE: the default assignment first guarantees no latch is inferred on any path.
  always_comb begin
    next_state = state;
    case (state)
      ALIGN:     next_state = WAIT_LOCK;
      WAIT_LOCK: begin
        if (wr_ok)                                   next_state = ALIGN;
        else if (lock_cnt == LOCK_W'(LOCK_CYCLES-1)) next_state = LOCKED;
      end
      LOCKED:    if (wr_ok) next_state = ALIGN;
      default:   next_state = ALIGN;
    endcase
  end

  // Output decode; outputs are gated off the cycle the state leaves or enters LOCKED
  always_comb begin
    cfg_ready = (state != ALIGN);
    run       = (state == LOCKED) && (next_state == LOCKED);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst)                                                   lock_cnt <= '0;
    else if ((state == WAIT_LOCK) && (next_state == WAIT_LOCK)) lock_cnt <= lock_cnt + LOCK_W'(1);
    else                                                       lock_cnt <= '0;
  end

  // NOTE: the per-channel config arrays are only NUM_CH entries of flops, so they carry a real reset.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div[i]   <= CNT_W'(2);
        high[i]  <= CNT_W'(1);
`ifdef DIVGEN_PHASE_EN
        phase[i] <= '0;
`endif
      end
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (int'(cfg_ch) == i) begin
          div[i]   <= cfg_div;
          high[i]  <= cfg_high;
`ifdef DIVGEN_PHASE_EN
          phase[i] <= cfg_phase;
`endif
        end
      end
    end
  end

  // Channel counters; >= on the wrap keeps them bounded if div shrinks before realignment
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (state == ALIGN) begin
`ifdef DIVGEN_PHASE_EN
          cnt[i] <= (phase[i] == '0) ? '0 : div[i] - phase[i];
`else
          cnt[i] <= '0;
`endif
        end else if (cnt[i] >= div[i] - CNT_W'(1)) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      outclk    <= '0;
      outclk_en <= '0;
      locked    <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      locked  <= (next_state == LOCKED);
      cfg_err <= accept && bad;
      for (int i = 0; i < NUM_CH; i++) begin
        outclk[i]    <= run && (cnt[i] < high[i]);
        outclk_en[i] <= run && (cnt[i] == '0);
      end
    end
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed self-checking bench for clk_div_gen (default parameters, with or without DIVGEN_PHASE_EN).
module tb_clk_div_gen;

  logic       refclk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div, cfg_high, cfg_phase;
  logic       cfg_err;
  logic [2:0] outclk, outclk_en;
  logic       locked;

  int n_checks = 0;
  int n_pass   = 0;

  clk_div_gen dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_phase (cfg_phase),
    .cfg_err   (cfg_err),
    .outclk    (outclk),
    .outclk_en (outclk_en),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] div;
    logic [7:0] high;
    logic [7:0] phase;
    logic       exp_err;
  } wr_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  task automatic drive_write(input logic [1:0] ch, input logic [7:0] dv, input logic [7:0] hi,
                             input logic [7:0] ph);
    cfg_ch    = ch;
    cfg_div   = dv;
    cfg_high  = hi;
    cfg_phase = ph;
    cfg_valid = 1'b1;
  endtask

  // Called right after the reference edge; locked must rise on the 17th edge after it.
  task automatic expect_relock(input string name);
    repeat (16) tick();
    check({name, "_not_yet_locked"}, 32'(locked), 32'd0);
    tick();
    check({name, "_locked"}, 32'(locked), 32'd1);
    check({name, "_outclk_idle"}, 32'(outclk), 32'd0);
  endtask

  task automatic expect_default_pattern(input string name);
    for (int j = 0; j < 4; j++) begin
      tick();
      check({name, "_outclk"}, 32'(outclk), (j % 2 == 0) ? 32'h7 : 32'h0);
      check({name, "_outclk_en"}, 32'(outclk_en), (j % 2 == 0) ? 32'h7 : 32'h0);
    end
  endtask

  wr_vec_t    bad_writes [5];
  logic [11:0] c1_clk, c1_en, c0_clk;
  logic [7:0]  c2_clk, c2_en, c0_clk8;

  initial begin
    bad_writes[0] = '{ch: 2'd0, div: 8'd1, high: 8'd1, phase: 8'd0, exp_err: 1'b1};
    bad_writes[1] = '{ch: 2'd0, div: 8'd5, high: 8'd5, phase: 8'd0, exp_err: 1'b1};
    bad_writes[2] = '{ch: 2'd1, div: 8'd4, high: 8'd0, phase: 8'd0, exp_err: 1'b1};
    bad_writes[3] = '{ch: 2'd3, div: 8'd4, high: 8'd2, phase: 8'd0, exp_err: 1'b1};
    bad_writes[4] = '{ch: 2'd2, div: 8'd0, high: 8'd0, phase: 8'd0, exp_err: 1'b1};

    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_high = '0; cfg_phase = '0;
    #12;
    check("rst_locked",    32'(locked),    32'd0);
    check("rst_outclk",    32'(outclk),    32'd0);
    check("rst_outclk_en", 32'(outclk_en), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_cfg_err",   32'(cfg_err),   32'd0);
    @(negedge refclk);
    rst = 1'b0;
    expect_relock("boot");
    expect_default_pattern("boot");

    // Rejected writes: one-cycle error pulse, lock undisturbed
    foreach (bad_writes[v]) begin
      drive_write(bad_writes[v].ch, bad_writes[v].div, bad_writes[v].high, bad_writes[v].phase);
      tick();
      cfg_valid = 1'b0;
      check($sformatf("bad%0d_err", v), 32'(cfg_err), 32'(bad_writes[v].exp_err));
      check($sformatf("bad%0d_locked", v), 32'(locked), 32'd1);
      tick();
      check($sformatf("bad%0d_err_clear", v), 32'(cfg_err), 32'd0);
      check($sformatf("bad%0d_still_locked", v), 32'(locked), 32'd1);
    end

    // ch1 div=6 high=2: relock then 110000 on ch1, ch0 untouched by rejected writes
    drive_write(2'd1, 8'd6, 8'd2, 8'd0);
    tick();
    cfg_valid = 1'b0;
    check("c1_err", 32'(cfg_err), 32'd0);
    check("c1_locked_drop", 32'(locked), 32'd0);
    check("c1_ready_align", 32'(cfg_ready), 32'd0);
    expect_relock("c1");
    c1_clk = 12'b001100001100;
    c1_en  = 12'b001000001000;
    c0_clk = 12'b101010101010;
    for (int j = 0; j < 12; j++) begin
      tick();
      check($sformatf("c1_outclk1_%0d", j), 32'(outclk[1]), 32'(c1_clk[11-j]));
      check($sformatf("c1_en1_%0d", j), 32'(outclk_en[1]), 32'(c1_en[11-j]));
      check($sformatf("c1_outclk0_%0d", j), 32'(outclk[0]), 32'(c0_clk[11-j]));
    end

    // ch2 div=4 high=2 phase=1: rising edge trails ch0 by one cycle only with the phase feature
    drive_write(2'd2, 8'd4, 8'd2, 8'd1);
    tick();
    cfg_valid = 1'b0;
    check("c2_err", 32'(cfg_err), 32'd0);
    expect_relock("c2");
    c0_clk8 = 8'b10101010;
`ifdef DIVGEN_PHASE_EN
    c2_clk = 8'b01100110;
    c2_en  = 8'b01000100;
`else
    c2_clk = 8'b11001100;
    c2_en  = 8'b10001000;
`endif
    for (int j = 0; j < 8; j++) begin
      tick();
      check($sformatf("c2_outclk2_%0d", j), 32'(outclk[2]), 32'(c2_clk[7-j]));
      check($sformatf("c2_en2_%0d", j), 32'(outclk_en[2]), 32'(c2_en[7-j]));
      check($sformatf("c2_outclk0_%0d", j), 32'(outclk[0]), 32'(c0_clk8[7-j]));
    end

    // Second valid write five cycles into WAIT_LOCK restarts the lock count
    drive_write(2'd1, 8'd6, 8'd2, 8'd0);
    tick();
    cfg_valid = 1'b0;
    check("rw_locked_drop", 32'(locked), 32'd0);
    tick();
    check("rw_ready_wait", 32'(cfg_ready), 32'd1);
    repeat (4) tick();
    drive_write(2'd1, 8'd6, 8'd2, 8'd0);
    tick();
    cfg_valid = 1'b0;
    check("rw_err", 32'(cfg_err), 32'd0);
    check("rw_locked", 32'(locked), 32'd0);
    expect_relock("rw");
    tick();
    check("rw_outclk0_high", 32'(outclk[0]), 32'd1);

    // Asynchronous reset mid-cycle with a write in flight
    drive_write(2'd1, 8'd6, 8'd3, 8'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_locked",    32'(locked),    32'd0);
    check("arst_outclk",    32'(outclk),    32'd0);
    check("arst_outclk_en", 32'(outclk_en), 32'd0);
    check("arst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("arst_cfg_err",   32'(cfg_err),   32'd0);
    cfg_valid = 1'b0;
    @(negedge refclk);
    rst = 1'b0;
    expect_relock("arst");
    expect_default_pattern("arst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
